// File: rtl/prei_pkg.sv
// Shared types and widths for the pre-intra LCU scheduler.
package prei_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam int MODE_W      = 6;
    localparam int COST_W      = 28;
    localparam int MODE_ADDR_W = 7;

endpackage

// File: rtl/prei_done_fifo.sv
// Two-entry completion queue; entry i owns mode-RAM bank i, so the pointers double as bank selects.
module prei_done_fifo
    import prei_pkg::*;
#(
    parameter int XY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [XY_W-1:0]   push_x_i,
    input  logic [XY_W-1:0]   push_y_i,
    input  logic [COST_W-1:0] push_cost_i,
    input  logic              release_i,
    output logic              wptr_o,
    output logic [1:0]        count_o,
    output logic              done_valid_o,
    output logic              done_bank_o,
    output logic [XY_W-1:0]   done_x_o,
    output logic [XY_W-1:0]   done_y_o,
    output logic [COST_W-1:0] done_cost_o,
    output logic              rel_err_o
);

    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        count_q, count_d;
    logic [XY_W-1:0]   x_q[2], x_d[2];
    logic [XY_W-1:0]   y_q[2], y_d[2];
    logic [COST_W-1:0] cost_q[2], cost_d[2];
    logic              pop;

    assign pop = release_i && (count_q != 2'd0);

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned, which would infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        x_d     = x_q;
        y_d     = y_q;
        cost_d  = cost_q;
        if (push_i) begin
            x_d[wptr_q]    = push_x_i;
            y_d[wptr_q]    = push_y_i;
            cost_d[wptr_q] = push_cost_i;
            wptr_d         = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        count_d = count_q + {1'b0, push_i} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
            // NOTE: the two entries are reset because done_* must read zero straight out of reset.
            for (int i = 0; i < 2; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                cost_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values regardless of statement order.
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cost_q  <= cost_d;
        end
    end

    assign wptr_o       = wptr_q;
    assign count_o      = count_q;
    assign done_valid_o = (count_q != 2'd0);
    assign done_bank_o  = rptr_q;
    assign done_x_o     = x_q[rptr_q];
    assign done_y_o     = y_q[rptr_q];
    assign done_cost_o  = cost_q[rptr_q];
    assign rel_err_o    = release_i && (count_q == 2'd0);

endmodule

// File: rtl/prei_sched.sv
// LCU scheduler for the pre-intra engine: job handshake, start pulse, ping-pong
// mode-RAM write steering and hand-off of completed LCUs downstream.
module prei_sched
    import prei_pkg::*;
#(
    parameter int LCU_XY_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lcu_valid_i,
    output logic                   lcu_ready_o,
    input  logic [LCU_XY_W-1:0]    lcu_x_i,
    input  logic [LCU_XY_W-1:0]    lcu_y_i,
    output logic                   md_enable_o,
    input  logic                   md_finish_i,
    input  logic [COST_W-1:0]      md_modebest64_i,
    input  logic                   md_we_i,
    input  logic [MODE_ADDR_W-1:0] md_waddr_i,
    input  logic [MODE_W-1:0]      md_wdata_i,
    output logic                   ram_we_o,
    output logic [MODE_ADDR_W:0]   ram_waddr_o,
    output logic [MODE_W-1:0]      ram_wdata_o,
    output logic                   done_valid_o,
    output logic                   done_bank_o,
    output logic [LCU_XY_W-1:0]    done_x_o,
    output logic [LCU_XY_W-1:0]    done_y_o,
    output logic [COST_W-1:0]      done_cost_o,
    input  logic                   done_release_i,
    output logic [CNT_W-1:0]       lcu_cnt_o,
    output logic                   err_o
);

    state_e               state_q, state_d;
    logic                 md_enable_q, md_enable_d;
    logic [LCU_XY_W-1:0]  x_q, x_d;
    logic [LCU_XY_W-1:0]  y_q, y_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 commit;
    logic                 wptr;
    logic [1:0]           count;
    logic                 rel_err;

    // A release landing in the same IDLE cycle cannot raise ready: count is the registered value.
    assign lcu_ready_o = (state_q == IDLE) && (count != 2'd2);
    assign commit      = md_finish_i && (state_q == RUN);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (lcu_valid_i && lcu_ready_o) begin
                    x_d     = lcu_x_i;
                    y_d     = lcu_y_i;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (md_finish_i) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        md_enable_d = (state_d == LAUNCH);
        err_d = err_q
              | (md_we_i && (state_q == IDLE))
              | (md_finish_i && (state_q != RUN))
              | rel_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            md_enable_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_enable_q <= md_enable_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign md_enable_o = md_enable_q;
    assign lcu_cnt_o   = cnt_q;
    assign err_o       = err_q;

    // Engine writes land in the bank the next commit will occupy.
    assign ram_we_o    = md_we_i && (state_q != IDLE);
    assign ram_waddr_o = {wptr, md_waddr_i};
    assign ram_wdata_o = md_wdata_i;

    prei_done_fifo #(
        .XY_W(LCU_XY_W)
    ) u_done_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (commit),
        .push_x_i     (x_q),
        .push_y_i     (y_q),
        .push_cost_i  (md_modebest64_i),
        .release_i    (done_release_i),
        .wptr_o       (wptr),
        .count_o      (count),
        .done_valid_o (done_valid_o),
        .done_bank_o  (done_bank_o),
        .done_x_o     (done_x_o),
        .done_y_o     (done_y_o),
        .done_cost_o  (done_cost_o),
        .rel_err_o    (rel_err)
    );

endmodule

// File: tb/tb_prei_sched.sv
// Self-checking bench for prei_sched: directed scenarios then randomized jobs,
// checked against a transaction-level queue model.
module tb_prei_sched;

    localparam int TB_CNT_W = 4;

    logic                clk;
    logic                rst;
    logic                lcu_valid_i;
    logic                lcu_ready_o;
    logic [7:0]          lcu_x_i, lcu_y_i;
    logic                md_enable_o;
    logic                md_finish_i;
    logic [27:0]         md_modebest64_i;
    logic                md_we_i;
    logic [6:0]          md_waddr_i;
    logic [5:0]          md_wdata_i;
    logic                ram_we_o;
    logic [7:0]          ram_waddr_o;
    logic [5:0]          ram_wdata_o;
    logic                done_valid_o;
    logic                done_bank_o;
    logic [7:0]          done_x_o, done_y_o;
    logic [27:0]         done_cost_o;
    logic                done_release_i;
    logic [TB_CNT_W-1:0] lcu_cnt_o;
    logic                err_o;

    prei_sched #(
        .LCU_XY_W(8),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lcu_valid_i    (lcu_valid_i),
        .lcu_ready_o    (lcu_ready_o),
        .lcu_x_i        (lcu_x_i),
        .lcu_y_i        (lcu_y_i),
        .md_enable_o    (md_enable_o),
        .md_finish_i    (md_finish_i),
        .md_modebest64_i(md_modebest64_i),
        .md_we_i        (md_we_i),
        .md_waddr_i     (md_waddr_i),
        .md_wdata_i     (md_wdata_i),
        .ram_we_o       (ram_we_o),
        .ram_waddr_o    (ram_waddr_o),
        .ram_wdata_o    (ram_wdata_o),
        .done_valid_o   (done_valid_o),
        .done_bank_o    (done_bank_o),
        .done_x_o       (done_x_o),
        .done_y_o       (done_y_o),
        .done_cost_o    (done_cost_o),
        .done_release_i (done_release_i),
        .lcu_cnt_o      (lcu_cnt_o),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: completed LCUs in order; banks alternate with every commit/release since reset.
    typedef struct {
        logic        bank;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [27:0] cost;
    } entry_t;

    entry_t              exp_q[$];
    int                  commits;
    logic                exp_err;
    logic [TB_CNT_W-1:0] exp_cnt;
    logic [7:0]          cur_x, cur_y;
    int                  checks = 0;
    int                  errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs();
        check("done_valid", done_valid_o, exp_q.size() != 0);
        check("ready_idle", lcu_ready_o, exp_q.size() < 2);
        if (exp_q.size() != 0) begin
            check("done_bank", done_bank_o, exp_q[0].bank);
            check("done_x", done_x_o, exp_q[0].x);
            check("done_y", done_y_o, exp_q[0].y);
            check("done_cost", done_cost_o, exp_q[0].cost);
        end
        check("lcu_cnt", lcu_cnt_o, exp_cnt);
        check("err", err_o, exp_err);
    endtask

    task automatic check_reset();
        check("rst_ready", lcu_ready_o, 1);
        check("rst_enable", md_enable_o, 0);
        check("rst_done_valid", done_valid_o, 0);
        check("rst_done_bank", done_bank_o, 0);
        check("rst_done_x", done_x_o, 0);
        check("rst_done_y", done_y_o, 0);
        check("rst_done_cost", done_cost_o, 0);
        check("rst_cnt", lcu_cnt_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ram_we", ram_we_o, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        check_reset();
        lcu_valid_i = 0; md_finish_i = 0; md_we_i = 0; done_release_i = 0;
        exp_q.delete();
        commits = 0;
        exp_err = 0;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] x, input logic [7:0] y);
        int waited = 0;
        lcu_valid_i = 1; lcu_x_i = x; lcu_y_i = y;
        #1;
        while (!lcu_ready_o && waited < 50) begin
            tick();
            waited++;
        end
        check("accept_timeout", waited < 50, 1);
        tick();
        lcu_valid_i = 0;
        check("enable_pulse", md_enable_o, 1);
        check("ready_busy", lcu_ready_o, 0);
        tick();
        check("enable_once", md_enable_o, 0);
        cur_x = x;
        cur_y = y;
    endtask

    task automatic release_entry();
        done_release_i = 1;
        tick();
        done_release_i = 0;
        if (exp_q.size() == 0) exp_err = 1;
        else void'(exp_q.pop_front());
        check_outputs();
    endtask

    task automatic run_engine(input int lat, input logic [27:0] cost, input bit rel,
                              input logic [6:0] waddr, input logic [5:0] wdata);
        logic   bank;
        entry_t e;
        bank = commits[0];
        for (int i = 0; i < lat; i++) begin
            md_we_i    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            md_waddr_i = waddr;
            md_wdata_i = wdata;
            #1;
            check("ram_we", ram_we_o, md_we_i);
            check("ram_waddr", ram_waddr_o, {bank, waddr});
            check("ram_wdata", ram_wdata_o, wdata);
            tick();
        end
        md_we_i = 0;
        md_finish_i = 1; md_modebest64_i = cost; done_release_i = rel;
        tick();
        md_finish_i = 0; done_release_i = 0;
        if (rel) begin
            if (exp_q.size() == 0) exp_err = 1;
            else void'(exp_q.pop_front());
        end
        e.bank = bank; e.x = cur_x; e.y = cur_y; e.cost = cost;
        exp_q.push_back(e);
        commits++;
        exp_cnt++;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lcu_valid_i = 0; lcu_x_i = 0; lcu_y_i = 0;
        md_finish_i = 0; md_modebest64_i = 0;
        md_we_i = 0; md_waddr_i = 0; md_wdata_i = 0;
        done_release_i = 0;
        reset_dut();
        check_outputs();

        // First LCU to bank 0, second to bank 1, both writing address 0x15.
        start_job(8'd3, 8'd5);
        run_engine(2, 28'h00ABCDE, 0, 7'h15, 6'd26);
        start_job(8'd7, 8'd9);
        run_engine(3, 28'h0123456, 0, 7'h15, 6'd26);

        // Queue full: third job held until a release; ready rises one cycle after it.
        lcu_valid_i = 1; lcu_x_i = 8'd11; lcu_y_i = 8'd13;
        repeat (2) begin
            tick();
            check("hold_ready", lcu_ready_o, 0);
            check("hold_enable", md_enable_o, 0);
        end
        done_release_i = 1;
        #1;
        check("ready_same_cycle", lcu_ready_o, 0);
        tick();
        done_release_i = 0;
        void'(exp_q.pop_front());
        check("ready_after_release", lcu_ready_o, 1);
        start_job(8'd11, 8'd13);
        run_engine(2, 28'h0FEDCBA, 0, 7'h2A, 6'd9);

        // Same-cycle commit and release with one entry queued.
        release_entry();
        check("pre_bank", done_bank_o, 0);
        start_job(8'd1, 8'd2);
        run_engine(1, 28'h0000042, 1, 7'h01, 6'd1);
        check("flip_bank", done_bank_o, 1);
        release_entry();
        check("one_left_empty", done_valid_o, 0);

        // Protocol errors, each from a clean reset, and their stickiness.
        release_entry();
        tick();
        check("err_sticky", err_o, 1);
        reset_dut();
        md_finish_i = 1;
        tick();
        md_finish_i = 0;
        exp_err = 1;
        check_outputs();
        reset_dut();
        md_we_i = 1; md_waddr_i = 7'h33;
        #1;
        check("ram_we_idle", ram_we_o, 0);
        tick();
        md_we_i = 0;
        exp_err = 1;
        check_outputs();

        // Reset in RUN, late finish after reset, then a fresh job lands in bank 0.
        reset_dut();
        start_job(8'd20, 8'd30);
        md_we_i = 1;
        #2;
        reset_dut();
        md_finish_i = 1;
        tick();
        md_finish_i = 0;
        exp_err = 1;
        check_outputs();
        reset_dut();
        start_job(8'd21, 8'd31);
        run_engine(2, 28'h0000777, 0, 7'h15, 6'd26);
        check("bank_after_rst", done_bank_o, 0);
        release_entry();

        // Randomized jobs; enough commits to wrap the narrow counter.
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 2) release_entry();
            start_job(8'($urandom), 8'($urandom));
            run_engine(int'($urandom_range(1, 4)), 28'($urandom),
                       (exp_q.size() != 0) && ($urandom_range(0, 1) == 1),
                       7'($urandom), 6'($urandom));
            if (exp_q.size() != 0 && $urandom_range(0, 2) == 0) release_entry();
        end
        while (exp_q.size() != 0) release_entry();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prei_sched.md
# prei_sched

LCU-level scheduler for the pre-intra mode-decision engine. Accepts LCU jobs from the encoder top controller and issues the one-cycle `enable` pulse to the engine. Steers the engine's mode-RAM writes into one half of a ping-pong mode RAM and queues completed LCUs, with cost and position, for the downstream intra/RDO stage until it releases the bank. Sits between the encoder top FSM and the pre-intra engine.

## Interface
- `LCU_XY_W`, default 8: width of LCU x/y coordinates.
- `CNT_W`, default 16: width of the completed-LCU counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `lcu_valid_i` in 1: LCU job request.
- `lcu_ready_o` out 1: job accepted when valid&&ready at a rising edge.
- `lcu_x_i`, `lcu_y_i` in LCU_XY_W: job position.
- `md_enable_o` out 1: one-cycle start pulse to the engine.
- `md_finish_i` in 1: engine done pulse.
- `md_modebest64_i` in 28: engine 64x64 best cost, valid with finish.
- `md_we_i` in 1, `md_waddr_i` in 7, `md_wdata_i` in 6: engine mode-RAM write.
- `ram_we_o` out 1, `ram_waddr_o` out 8, `ram_wdata_o` out 6: ping-pong mode-RAM write port.
- `done_valid_o` out 1: oldest completed LCU available.
- `done_bank_o` out 1, `done_x_o`/`done_y_o` out LCU_XY_W, `done_cost_o` out 28: oldest entry.
- `done_release_i` in 1: consumer frees the oldest entry.
- `lcu_cnt_o` out CNT_W: completed LCUs, wraps.
- `err_o` out 1: sticky protocol error.

## Operation
- 2-entry completion queue.
  - `wptr`, `rptr` are 1 bit each; `count` is 0..2.
  - Entry i owns mode-RAM bank i.
- FSM states: IDLE, LAUNCH, RUN.
  - IDLE: `lcu_ready_o` = (count<2). On accept, latch x/y and go to LAUNCH.
  - LAUNCH: `md_enable_o`=1 for exactly this cycle, then RUN.
  - RUN: wait for `md_finish_i`. On finish, write {x, y, `md_modebest64_i`} into entry `wptr`, toggle `wptr`, count+1, increment `lcu_cnt_o`, go to IDLE.
- Write steering is combinational:
  - `ram_we_o` = `md_we_i` && state!=IDLE.
  - `ram_waddr_o` = {wptr, md_waddr_i}.
  - `ram_wdata_o` = `md_wdata_i`.
  - Writes arriving in IDLE are dropped and set `err_o`.
- Output queue:
  - `done_valid_o` = count!=0.
  - `done_*` reflect entry `rptr`; `done_bank_o` = rptr.
  - `done_release_i` with count!=0 toggles `rptr` and decrements count.
  - `done_release_i` with count==0 is ignored and sets `err_o`.
- Boundary cases:
  - Commit and release in the same cycle: count unchanged, both pointers toggle.
  - Queue full (count==2): `lcu_ready_o`=0. Pending valid holds until a release. A release in the same IDLE cycle does not raise ready; ready rises the next cycle.
  - `md_finish_i` outside RUN: ignored, sets `err_o`.
  - `err_o` clears only on reset.
  - `lcu_cnt_o` wraps 2^CNT_W-1 → 0.

## Timing
- Reset values:
  - state=IDLE.
  - `lcu_ready_o`=1 (since count=0).
  - `md_enable_o`=0, `done_valid_o`=0, `done_bank_o`=0.
  - `done_x_o`/`done_y_o`/`done_cost_o`=0.
  - `lcu_cnt_o`=0, `err_o`=0.
  - `ram_we_o`=0, since state is IDLE.
- Accept at edge T: `md_enable_o`=1 during cycle T+1, and RUN from T+2.
- Finish sampled at edge F: `done_valid_o`=1 and `lcu_ready_o`=1 (if count<2) from F+1.
- Minimum accept-to-accept spacing is 3 cycles plus engine latency.
- Reset asserted mid-LCU: all state clears immediately. A late engine finish after reset is an error (`err_o`=1). The top level must reset the engine together with this block.

## Structure
- Shared package `prei_pkg`: FSM state encoding (IDLE=2'd0, LAUNCH=2'd1, RUN=2'd2), MODE_W=6, COST_W=28, MODE_ADDR_W=7.
- One natural sub-module, `prei_done_fifo`: the 2-entry queue with pointers, count and release logic.
- The FSM and write steering stay in `prei_sched`.

## Test plan
- Reset, then one job at x=3,y=5. `md_enable_o` pulses exactly 1 cycle, at accept+1. Finish with cost 28'h00ABCDE: `done_valid_o`=1 next cycle with bank 0, x=3, y=5, cost 28'h00ABCDE, and `lcu_cnt_o`=1.
- Engine writes addr 7'h15, data 6'd26 during the first and second LCU. `ram_waddr_o`=8'h15 for the first, 8'h95 for the second; data is passed through.
- Three jobs, no release. The third is held with `lcu_ready_o`=0 after two commits. A release raises ready the next cycle; the third job then writes bank 0.
- Commit and release in the same cycle with count=1: count stays 1, `done_bank_o` flips 0→1, and `err_o` stays 0.
- Release with empty queue, and finish in IDLE: each sets `err_o`=1, which stays set until `rst`.
- Assert `rst` during RUN: all outputs return to reset values, and a new job after reset uses bank 0.
